// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_tx4 frame transmitter.
//   state_t        : transmitter FSM states (3-bit encoding)
//   LINE_IDLE/START: serial line levels
//   DEF_*          : default WIDTH / CLKS_PER_BIT
//   cnt_width()    : counter width helper, clog2(n) with a minimum of 1
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx4_bit_timer.sv
// Bit-period timer for serial_tx4.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear (frame acceptance)
//   tick  : high on the terminal count of each CLKS_PER_BIT-cycle period
// With CLKS_PER_BIT=1 the counter is omitted and tick is constant 1.
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_bypass
            assign tick = 1'b1;
        end else begin : g_count
            localparam int TW = cnt_width(CLKS_PER_BIT);
            localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);

            logic [TW-1:0] timer;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    timer <= '0;
                end else if (clr || (timer == TLAST)) begin
                    timer <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end

            assign tick = (timer == TLAST);
        end
    endgenerate

endmodule

// File: rtl/serial_tx4.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start bit (0), WIDTH data bits LSB-first, optional even parity,
// stop bit (1); every bit is held CLKS_PER_BIT cycles.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   load  : send request, accepted only while ready=1
//   d     : parallel data word
//   ready : idle and able to accept load
//   busy  : frame in progress (always ~ready)
//   tx    : serial line, idles high
//   done  : one-cycle pulse in the first idle cycle after the stop bit
// Define SERIAL_TX4_PARITY_EN to insert an even-parity bit before stop.
module serial_tx4
    import serial_tx_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [BW-1:0]    bitcnt;
    logic             tick;
    logic             accept;
`ifdef SERIAL_TX4_PARITY_EN
    logic             parity;
`endif

    assign accept  = (state == ST_IDLE) && load;
    assign sr_next = sr >> 1;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    // tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            tx     <= LINE_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            bitcnt <= '0;
            sr     <= '0;
`ifdef SERIAL_TX4_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx    <= LINE_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    if (load) begin
                        sr    <= d;
`ifdef SERIAL_TX4_PARITY_EN
                        parity <= ^d;
`endif
                        state <= ST_START;
                        tx    <= LINE_START;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state  <= ST_DATA;
                        tx     <= sr[0];
                        bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        sr <= sr_next;
                        if (bitcnt == LAST_BIT) begin
`ifdef SERIAL_TX4_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity;
`else
                            state <= ST_STOP;
                            tx    <= LINE_IDLE;
`endif
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= sr_next[0];
                        end
                    end
                end
`ifdef SERIAL_TX4_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= LINE_IDLE;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        tx    <= LINE_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= LINE_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx4.sv
// Self-checking bench for serial_tx4: one instance with default parameters
// and one with CLKS_PER_BIT=1, selected by 'sel'. Expected line levels come
// from a frame model (bit index -> level) derived from the frame format.
module tb_serial_tx4;

    localparam int W  = 4;
    localparam int C  = 4;
`ifdef SERIAL_TX4_PARITY_EN
    localparam int NBITS = W + 3;
`else
    localparam int NBITS = W + 2;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic         sel = 1'b0;

    logic ready0, busy0, tx0, done0;
    logic ready1, busy1, tx1, done1;
    logic ready_s, busy_s, tx_s, done_s;
    logic load0, load1;

    int checks = 0;
    int errors = 0;

    assign load0   = load & ~sel;
    assign load1   = load & sel;
    assign ready_s = sel ? ready1 : ready0;
    assign busy_s  = sel ? busy1  : busy0;
    assign tx_s    = sel ? tx1    : tx0;
    assign done_s  = sel ? done1  : done0;

    serial_tx4 #(.WIDTH(W), .CLKS_PER_BIT(C)) u_dut (
        .clk(clk), .reset(reset), .load(load0), .d(d),
        .ready(ready0), .busy(busy0), .tx(tx0), .done(done0)
    );

    serial_tx4 #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load1), .d(d),
        .ready(ready1), .busy(busy1), .tx(tx1), .done(done1)
    );

    always #5 clk = ~clk;

    // Line level for bit slot b of a frame carrying v.
    function automatic logic exp_tx(input logic [W-1:0] v, input int b);
        if (b == 0) return 1'b0;
        if (b <= W) return v[b-1];
`ifdef SERIAL_TX4_PARITY_EN
        if (b == W + 1) return ^v;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, tx_s, 1);
        chk({tag, "_ready"}, ready_s, 1);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_done"}, done_s, 0);
    endtask

    task automatic start(input logic [W-1:0] v);
        @(negedge clk);
        load = 1'b1;
        d    = v;
    endtask

    // Expects load/d already driven for the next rising edge.
    task automatic frame(input logic [W-1:0] v, input bit spurious,
                         input bit chain, input logic [W-1:0] v2);
        int cpb;
        int len;
        cpb = sel ? 1 : C;
        len = NBITS * cpb;
        @(posedge clk);
        #1;
        load = 1'b0;
        d    = W'($urandom);
        for (int cyc = 0; cyc < len; cyc++) begin
            @(negedge clk);
            chk("frame_tx", tx_s, exp_tx(v, cyc / cpb));
            chk("frame_busy", busy_s, 1);
            chk("frame_ready", ready_s, 0);
            chk("frame_done", done_s, 0);
            if (spurious && cyc == 2 * cpb) begin
                load = 1'b1;
                d    = '1;
            end
            if (spurious && cyc == 2 * cpb + 1) load = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", done_s, 1);
        chk("done_ready", ready_s, 1);
        chk("done_busy", busy_s, 0);
        chk("done_tx", tx_s, 1);
        if (chain) begin
            load = 1'b1;
            d    = v2;
        end else begin
            @(negedge clk);
            chk_idle("post");
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] v2;

        // Reset then idle
        repeat (3) @(negedge clk);
        chk_idle("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // Directed frames
        start(4'b0101);
        frame(4'b0101, 1'b0, 1'b0, '0);
        start(4'b0011);
        frame(4'b0011, 1'b0, 1'b1, 4'b1100);
        frame(4'b1100, 1'b0, 1'b0, '0);
        start(4'b0001);
        frame(4'b0001, 1'b1, 1'b0, '0);

        // Randomized frames, some chained
        for (int n = 0; n < 6; n++) begin
            v  = W'($urandom);
            v2 = W'($urandom);
            start(v);
            if ($urandom_range(0, 1) == 1) begin
                frame(v, 1'b0, 1'b1, v2);
                frame(v2, 1'b0, 1'b0, '0);
            end else begin
                frame(v, 1'b0, 1'b0, '0);
            end
        end

        // Reset during data bit 2 (slot 3), with bit 2 low so tx visibly rises
        v = W'($urandom) & 4'b1011;
        start(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_reset_tx", tx_s, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("async_tx", tx_s, 1);
        chk("async_ready", ready_s, 1);
        chk("async_busy", busy_s, 0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_done", done_s, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2 * C * NBITS; i++) begin
            @(negedge clk);
            chk_idle("after_abort");
        end
        v = W'($urandom);
        start(v);
        frame(v, 1'b0, 1'b0, '0);

        // CLKS_PER_BIT=1 instance
        sel = 1'b1;
        @(negedge clk);
        chk_idle("c1_idle");
        start(4'b0111);
        frame(4'b0111, 1'b0, 1'b0, '0);
        for (int n = 0; n < 4; n++) begin
            v  = W'($urandom);
            v2 = W'($urandom);
            start(v);
            frame(v, 1'b0, 1'b1, v2);
            frame(v2, 1'b1, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
